// File: rtl/udp_tx_pkg.sv
// Shared definitions for the UDP digit transmitter: FSM encoding, payload byte map
// and default frame length.
package udp_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int VAL_B0 = 0;
  localparam int VAL_B1 = 1;
  localparam int VAL_B2 = 2;
  localparam int VAL_B3 = 3;
  localparam int SEQ_HI = 4;
  localparam int SEQ_LO = 5;

  localparam int DEFAULT_PAYLOAD_LEN = 8;

endpackage

// File: rtl/udp_tx_payload_mux.sv
// Byte-index to payload byte select: value MSB-first, then sequence number, then zero fill.
module udp_tx_payload_mux
  import udp_tx_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      value_i,
  input  logic [15:0]      seq_i,
  output logic [7:0]       byte_o
);

  always_comb begin
    byte_o = 8'h00;
    case (32'(idx_i))
      VAL_B0:  byte_o = value_i[31:24];
      VAL_B1:  byte_o = value_i[23:16];
      VAL_B2:  byte_o = value_i[15:8];
      VAL_B3:  byte_o = value_i[7:0];
      SEQ_HI:  byte_o = seq_i[15:8];
      SEQ_LO:  byte_o = seq_i[7:0];
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/udp_tx_digits.sv
// Sends a captured 32-bit value as a fixed-length UDP payload via the app_tx port.
// Optional periodic sending is enabled with the UDP_TX_AUTO_EN macro.
module udp_tx_digits
  import udp_tx_pkg::*;
#(
  parameter int PAYLOAD_LEN = DEFAULT_PAYLOAD_LEN,
  parameter int REQ_TIMEOUT = 1_000_000,
`ifdef UDP_TX_AUTO_EN
  parameter int AUTO_PERIOD = 125_000_000,
`endif
  parameter int IFG_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send_start,
  input  logic [31:0] send_value,
  input  logic        udp_tx_ready,
  input  logic        app_tx_ack,
  output logic        app_tx_data_request,
  output logic        app_tx_data_valid,
  output logic [7:0]  app_tx_data,
  output logic [15:0] app_tx_data_length,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_timeout,
  output logic [15:0] seq_num,
  output logic [1:0]  dbg_state
);

  localparam int BW = $clog2(PAYLOAD_LEN + 1);
  localparam int TW = $clog2(REQ_TIMEOUT + 1);
  localparam int GW = $clog2(IFG_CYCLES + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(PAYLOAD_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(REQ_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(IFG_CYCLES - 1);

  state_t        state_q, state_d;
  logic          pending_q, pending_d;
  logic [31:0]   value_q, value_d;
  logic [15:0]   seq_q, seq_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          tx_done_q, tx_done_d;
  logic          tx_timeout_q, tx_timeout_d;

  logic          trig, grant, accept, send_last, req_tmo;
  logic [7:0]    mux_byte;

`ifdef UDP_TX_AUTO_EN
  localparam int PW = $clog2(AUTO_PERIOD + 1);
  localparam logic [PW-1:0] PER_LAST = PW'(AUTO_PERIOD - 1);
  logic [PW-1:0] per_q, per_d;
  logic          auto_trig;

  assign auto_trig = (per_q == PER_LAST);
  assign per_d     = auto_trig ? '0 : per_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) per_q <= '0;
    else       per_q <= per_d;
  end

  assign trig = send_start | auto_trig;
`else
  assign trig = send_start;
`endif

  // Grant only counts while the stack reports ready; stray acks are ignored.
  assign grant     = app_tx_ack & udp_tx_ready;
  assign accept    = (state_q == ST_IDLE) && (trig || pending_q);
  assign send_last = (state_q == ST_SEND) && (byte_q == LAST_BYTE);
  assign req_tmo   = (state_q == ST_REQ) && !grant && (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ: begin
        if (grant)        state_d = ST_SEND;
        else if (req_tmo) state_d = ST_GAP;
      end
      ST_SEND: if (send_last) state_d = ST_GAP;
      ST_GAP:  if (gap_q == GAP_LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A trigger arriving on the accepting IDLE cycle is kept pending only when
  // the accept itself was caused by an earlier pending request.
  always_comb begin
    pending_d    = (state_q == ST_IDLE) ? (pending_q & trig) : (pending_q | trig);
    value_d      = accept ? send_value : value_q;
    seq_d        = send_last ? seq_q + 16'd1 : seq_q;
    byte_d       = (state_q == ST_SEND) ? byte_q + 1'b1 : '0;
    tmo_d        = (state_q == ST_REQ) ? tmo_q + 1'b1 : '0;
    gap_d        = (state_q == ST_GAP) ? gap_q + 1'b1 : '0;
    tx_done_d    = send_last;
    tx_timeout_d = req_tmo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= 1'b0;
      value_q      <= '0;
      seq_q        <= '0;
      byte_q       <= '0;
      tmo_q        <= '0;
      gap_q        <= '0;
      tx_done_q    <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      value_q      <= value_d;
      seq_q        <= seq_d;
      byte_q       <= byte_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      tx_done_q    <= tx_done_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  udp_tx_payload_mux #(.IDX_W(BW)) u_mux (
    .idx_i   (byte_q),
    .value_i (value_q),
    .seq_i   (seq_q),
    .byte_o  (mux_byte)
  );

  always_comb begin
    app_tx_data_request = (state_q == ST_REQ);
    app_tx_data_valid   = (state_q == ST_SEND);
    app_tx_data         = (state_q == ST_SEND) ? mux_byte : 8'h00;
    busy                = (state_q != ST_IDLE);
  end

  assign app_tx_data_length = 16'(PAYLOAD_LEN);
  assign tx_done            = tx_done_q;
  assign tx_timeout         = tx_timeout_q;
  assign seq_num            = seq_q;
  assign dbg_state          = state_q;

endmodule
